// File: rtl/grng_sample_reader.sv
// Capture stage for the Gaussian sample stream.
// Buffers a programmed run of samples and re-issues them on valid/ready.
module grng_sample_reader #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16,
  parameter int SKIP   = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_sample,
  input  logic              in_valid,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_samples,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = (SKIP > 1) ? $clog2(SKIP) : 1;
  localparam logic [AW:0]      PTR_ONE = (AW+1)'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [SW-1:0]    SK_ONE  = SW'(1);
  localparam logic [SW-1:0]    SK_LAST = SW'(SKIP - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SKIP,
    S_CAPTURE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic [CNT_W-1:0]  num_q;
  logic [CNT_W-1:0]  acc_cnt;
  logic [SW-1:0]     skip_cnt;

  logic empty;
  logic full;
  logic pop;
  logic push;
  logic drop;
  logic last_push;
  logic capturing;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign out_valid = !empty;
  assign out_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // A pop frees the slot this cycle, so a full FIFO still accepts.
  assign capturing = (state == S_CAPTURE) && in_valid;
  assign pop       = out_valid && out_ready;
  assign push      = capturing && (!full || pop);
  assign drop      = capturing && full && !pop;
  assign last_push = push && ((acc_cnt + CNT_ONE) == num_q);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= in_sample;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      num_q      <= '0;
      acc_cnt    <= '0;
      skip_cnt   <= '0;
      drop_count <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            num_q      <= num_samples;
            acc_cnt    <= '0;
            skip_cnt   <= '0;
            drop_count <= '0;
            if (num_samples == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else if (SKIP == 0) begin
              state <= S_CAPTURE;
              busy  <= 1'b1;
            end else begin
              state <= S_SKIP;
              busy  <= 1'b1;
            end
          end
        end
        S_SKIP: begin
          if (in_valid) begin
            skip_cnt <= skip_cnt + SK_ONE;
            if (skip_cnt == SK_LAST) begin
              state <= S_CAPTURE;
            end
          end
        end
        S_CAPTURE: begin
          if (push) begin
            acc_cnt <= acc_cnt + CNT_ONE;
          end
          if (drop && !(&drop_count)) begin
            drop_count <= drop_count + CNT_ONE;
          end
          if (last_push) begin
            state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (empty) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
